// File: rtl/gpio_adder_responder.sv
// gpio_adder_responder
//   Bit-serial adder behind a four-phase req/ack handshake driven by a PS GPIO
//   initiator. A rising req in IDLE captures the operands. The adder then
//   processes one bit per clock, LSB first. After WIDTH bit-steps the result is
//   published on sum/cout and ack is raised. ack is held until req is seen low.
//
// Ports
//   clk      : single clock, rising edge
//   rst_n    : asynchronous active-low reset
//   op_a     : operand A (WIDTH bits), sampled only on the start edge
//   op_b     : operand B (WIDTH bits), sampled only on the start edge
//   cin      : carry-in, sampled only on the start edge
//   req      : four-phase request
//   sum      : registered result (WIDTH bits), held until the next completion
//   cout     : registered carry-out
//   busy     : high while the serial addition is running
//   ack      : four-phase acknowledge
//   op_count : completed additions, wraps modulo 256
module gpio_adder_responder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin,
   input  logic             req,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy,
   output logic             ack,
   output logic [7:0]       op_count
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

   state_t           r_state;
   state_t           w_state_next;

   logic             r_req_q;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_c;
   logic [WIDTH-1:0] r_res;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_busy;
   logic             r_ack;
   logic [7:0]       r_op_count;

   logic             w_start;
   logic             w_load;
   logic             w_step;
   logic             w_finish;
   logic             w_release;
   logic             w_sum_bit;
   logic             w_carry;
   logic [WIDTH-1:0] w_res_next;

   // Full adder on the current LSBs of the operand shift registers.
   assign w_sum_bit = r_a[0] ^ r_b[0] ^ r_c;
   assign w_carry   = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);

   // Result bits enter at the MSB and move down, so after WIDTH steps the
   // first (LSB) bit has reached position 0. The concatenation also keeps
   // WIDTH=1 legal.
   logic [WIDTH:0] w_res_concat;
   assign w_res_concat = {w_sum_bit, r_res};
   assign w_res_next   = w_res_concat[WIDTH:1];

   // Edge-detect on req. r_req_q resets high, so a req already high when reset
   // is released does not look like a new request.
   assign w_start = (r_state == IDLE) && req && !r_req_q;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic and datapath strobes.
   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_step       = 1'b0;
      w_finish     = 1'b0;
      w_release    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_start) begin
               w_load       = 1'b1;
               w_state_next = ADD;
            end
         end
         ADD: begin
            // req is deliberately ignored here. A dropped req still completes.
            w_step = 1'b1;
            if (r_cnt == LAST_BIT) begin
               w_finish     = 1'b1;
               w_state_next = DONE;
            end
         end
         DONE: begin
            if (!req) begin
               w_release    = 1'b1;
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_req_q    <= 1'b1;
         r_a        <= '0;
         r_b        <= '0;
         r_c        <= 1'b0;
         r_res      <= '0;
         r_cnt      <= '0;
         r_sum      <= '0;
         r_cout     <= 1'b0;
         r_busy     <= 1'b0;
         r_ack      <= 1'b0;
         r_op_count <= 8'd0;
      end else begin
         r_req_q <= req;
         if (w_load) begin
            r_a    <= op_a;
            r_b    <= op_b;
            r_c    <= cin;
            r_res  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
         end
         if (w_step) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_c   <= w_carry;
            r_res <= w_res_next;
            r_cnt <= r_cnt + CW'(1);
         end
         // sum/cout change only here. They stay stable for the whole ADD phase.
         if (w_finish) begin
            r_sum      <= w_res_next;
            r_cout     <= w_carry;
            r_ack      <= 1'b1;
            r_busy     <= 1'b0;
            r_op_count <= r_op_count + 8'd1;
         end
         if (w_release) begin
            r_ack <= 1'b0;
         end
      end
   end

   assign sum      = r_sum;
   assign cout     = r_cout;
   assign busy     = r_busy;
   assign ack      = r_ack;
   assign op_count = r_op_count;

endmodule

// File: tb/tb_gpio_adder_responder.sv
// tb_gpio_adder_responder
//   Scoreboard bench for gpio_adder_responder (WIDTH=8). Each request pushes the
//   expected sum/cout/op_count to a queue. A monitor pops that entry on every
//   rising edge of ack and compares it. The driver tasks also check cycle-exact
//   busy/ack timing and that sum holds its previous value during ADD.
module tb_gpio_adder_responder;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             cin;
   logic             req;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;
   logic             ack;
   logic [7:0]       op_count;

   gpio_adder_responder #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .op_a     (op_a),
      .op_b     (op_b),
      .cin      (cin),
      .req      (req),
      .sum      (sum),
      .cout     (cout),
      .busy     (busy),
      .ack      (ack),
      .op_count (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] sum;
      logic       cout;
      logic [7:0] cnt;
   } exp_t;

   exp_t       sb_q[$];
   int         n_vec  = 0;
   int         n_fail = 0;
   logic [7:0] exp_count = 8'd0;
   logic [7:0] prev_sum  = 8'd0;
   logic       ack_prev  = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Monitor: each completion (ack rising) must match the oldest pushed result.
   always @(negedge clk) begin
      exp_t e;
      if (ack && !ack_prev) begin
         check("sb_depth", 32'(sb_q.size() > 0), 32'd1);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_sum", 32'(sum), 32'(e.sum));
            check("sb_cout", 32'(cout), 32'(e.cout));
            check("sb_count", 32'(op_count), 32'(e.cnt));
            $display("txn: sum=0x%02h cout=%0d op_count=%0d", sum, cout, op_count);
         end
      end
      ack_prev = ack;
   end

   // One full handshake. change_at/drop_at name the ADD negedge index
   // (0 = just after the start edge) at which operands are zeroed or req is
   // dropped. Use -1 for neither.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input int change_at, input int drop_at);
      logic [8:0] full;
      exp_t       e;
      @(negedge clk);
      op_a = a; op_b = b; cin = c; req = 1'b1;
      full = {1'b0, a} + {1'b0, b} + 9'(c);
      exp_count = exp_count + 8'd1;
      e.sum = full[7:0]; e.cout = full[8]; e.cnt = exp_count;
      sb_q.push_back(e);
      @(posedge clk);
      for (int k = 0; k < WIDTH; k++) begin
         @(negedge clk);
         check("busy_add", 32'(busy), 32'd1);
         check("ack_add", 32'(ack), 32'd0);
         check("sum_hold", 32'(sum), 32'(prev_sum));
         if (k == change_at) begin
            op_a = 8'h00; op_b = 8'h00; cin = 1'b0;
         end
         if (k == drop_at) req = 1'b0;
      end
      @(negedge clk);
      check("ack_rise", 32'(ack), 32'd1);
      check("busy_fall", 32'(busy), 32'd0);
      prev_sum = full[7:0];
      if (drop_at >= 0) begin
         @(negedge clk);
         check("ack_pulse", 32'(ack), 32'd0);
      end else begin
         @(negedge clk);
         check("ack_hold", 32'(ack), 32'd1);
         req = 1'b0;
         @(negedge clk);
         check("ack_release", 32'(ack), 32'd0);
         check("busy_idle", 32'(busy), 32'd0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; req = 1'b1; op_a = '0; op_b = '0; cin = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_count", 32'(op_count), 32'd0);
      // req held high across reset release must not start an addition.
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("no_start_post_rst", 32'(busy), 32'd0);
      end
      req = 1'b0;
      @(negedge clk);

      run_op(8'h3C, 8'h5A, 1'b0, -1, -1);   // 0x96, cout 0, count 1
      run_op(8'hFF, 8'h01, 1'b0, -1, -1);   // 0x00, cout 1
      run_op(8'hFF, 8'hFF, 1'b1, -1, -1);   // 0xFF, cout 1
      run_op(8'h10, 8'h20, 1'b0, 2, -1);    // operands zeroed mid-add -> 0x30
      run_op(8'hA5, 8'h0F, 1'b1, -1, 3);    // req dropped during ADD
      run_op(8'h01, 8'h02, 1'b0, -1, -1);   // normal start after the drop

      // Abort at ADD cycle 4 with an asynchronous reset.
      @(negedge clk);
      op_a = 8'h11; op_b = 8'h22; cin = 1'b0; req = 1'b1;
      @(posedge clk);
      repeat (5) @(negedge clk);
      check("busy_before_abort", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_ack", 32'(ack), 32'd0);
      check("abort_sum", 32'(sum), 32'd0);
      check("abort_count", 32'(op_count), 32'd0);
      exp_count = 8'd0;
      prev_sum  = 8'd0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("no_start_req_high", 32'(busy), 32'd0);
      end
      req = 1'b0;
      @(negedge clk);

      for (int n = 0; n < 256; n++) begin
         run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)), -1, -1);
      end
      check("wrap_256", 32'(op_count), 32'd0);
      run_op(8'h7F, 8'h01, 1'b0, -1, -1);
      check("wrap_257", 32'(op_count), 32'd1);

      check("sb_left", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
